dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the slave/target end of the processor's
//  load/store port. It accepts one request at a time over a valid/ready
//  handshake and inserts LATENCY wait cycles. It performs byte, halfword or
//  word reads and writes with RISC-V funct3 sizing and sign rules, then holds
//  a response until the processor accepts it. It replaces the zero-latency
//  dmem when the core is built with a stalling memory stage.
// PARAMETERS
//  DEPTH    64  number of 32-bit words in storage
//  LATENCY  2   wait cycles between request accept and access (0..15)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_we      in   1   1 = store, 0 = load
//  req_adr     in   32  byte address
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_funct3  in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   processor accepts response
//  rsp_rdata   out  32  load data, extended per funct3; 0 for stores and errors
//  rsp_err     out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, wait counter=0. Storage contents are NOT reset.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: req_ready=1. If req_valid, on the edge: latch we/adr/wdata/funct3,
//    load counter=LATENCY, go to WAIT.
//   WAIT: req_ready=0. If counter!=0, decrement. If counter==0, on the edge:
//    perform the access, register rdata/err, go to RESP.
//   RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err are stable until the
//    response is accepted. When rsp_ready is 1, go to IDLE on the edge.
//  Latency: request accepted at edge N -> rsp_valid high after edge N+1+LATENCY.
//   Max throughput is one request per LATENCY+3 cycles.
//  Word index = latched adr[31:2]. Byte lane = adr[1:0].
//  Errors: any of the following sets rsp_err=1, suppresses the write and
//   returns rdata=0:
//   - h/hu with adr[0]=1
//   - w with adr[1:0]!=0
//   - word index >= DEPTH
//   - funct3 in {011,110,111}
//   - store with funct3 100 or 101
//  Loads: select the lane, then extend.
//   - b/h sign-extend from bit 7/15
//   - bu/hu zero-extend
//   - w returns the full word
//  Stores: write only the addressed byte(s) from the low bits of wdata; all
//   other bytes of the word are preserved.
//  Reset asserted in WAIT or RESP: the pending access is dropped (no write).
//   The FSM returns to IDLE and the response is lost.
//  req_valid while not in IDLE is ignored. The requester must hold the request
//   stable until req_ready=1.
//  rsp_ready while not in RESP is ignored.
// TESTING
//  1 LATENCY=2: sw 0x12345678 @0x10, then lw @0x10 -> rdata=0x12345678,
//    err=0, rsp_valid exactly 3 edges after each accept.
//  2 sb 0x000000AB @0x11, then:
//    lbu @0x11 -> 0x000000AB
//    lb  @0x11 -> 0xFFFFFFAB
//    lw  @0x10 -> 0x1234AB78
//  3 lh @0x13 -> err=1, rdata=0. sh @0x12 with err-free data -> subsequent
//    lhu @0x12 returns the new half; a misaligned sw @0x12 -> err=1 and the
//    word is unchanged.
//  4 Hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rdata and err stable,
//    req_ready=0; a new req_valid is ignored until return to IDLE.
//  5 Drive reset low mid-WAIT of sw 0xDEADBEEF @0x20 -> IDLE, rsp_valid=0
//    immediately. A later lw @0x20 returns the prior contents.
//  6 DEPTH=64: lw @0x100 -> err=1. funct3=011 -> err=1. LATENCY=0 build:
//    rsp_valid 1 edge after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the load/store port
//
// Accepts one request at a time, waits LATENCY cycles, then performs a
// byte/half/word access with RISC-V funct3 sizing and holds the response
// until the processor takes it.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   req_we      1 = store, 0 = load
//   req_adr     byte address
//   req_wdata   store data, right-aligned
//   req_funct3  000 b, 001 h, 010 w, 100 bu, 101 hu
//   rsp_valid   response present
//   rsp_ready   processor accepts response
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     misaligned, out-of-range or illegal funct3
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic [31:0] mem [DEPTH];

  logic            do_access;
  logic [1:0]      lane;
  logic [IDXW-1:0] idx;
  logic            acc_err;
  logic            illegal, misaligned, out_of_range;
  logic [31:0]     rd_word, rd_shift, load_data;
  logic [3:0]      wmask;
  logic [31:0]     wbytes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access decode, all from the latched request.
  always_comb begin
    lane         = adr_q[1:0];
    idx          = adr_q[IDXW+1:2];
    out_of_range = (adr_q[31:2] >= 30'(DEPTH));
    illegal      = 1'b0;
    misaligned   = 1'b0;
    case (funct3_q)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = lane[0];
      3'b010:         misaligned = |lane;
      default:        illegal    = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (we_q && funct3_q[2]) illegal = 1'b1;
    acc_err = illegal | misaligned | out_of_range;

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase

    // Replicate store data across the word so the lane mask alone picks bytes.
    case (funct3_q[1:0])
      2'b00: begin
        wmask  = 4'b0001 << lane;
        wbytes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask  = 4'b0011 << lane;
        wbytes = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask  = 4'b1111;
        wbytes = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      wdata_q   <= 32'd0;
      funct3_q  <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        adr_q    <= req_adr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        cnt      <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
      end
    end
  end

  // Storage is not reset; reset forces state out of WAIT so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wbytes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_adr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
  logic [31:0] z_req_adr = '0, z_req_wdata = '0;
  logic [2:0]  z_req_funct3 = '0;
  logic        z_rsp_valid, z_rsp_ready = 1'b0, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mm [64];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_adr(z_req_adr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V load/store rules on a word array.
  task automatic model_access(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    int lane;
    logic [31:0] v;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    lane = int'(adr % 4);
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5))
           || (adr % size != 0) || ((adr / 4) >= 64);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int b = 0; b < size; b++) mm[adr / 4][8*(lane+b) +: 8] = wd[8*b +: 8];
    end else begin
      v = mm[adr / 4] / (32'd1 << (8*lane));
      if (size == 1) begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      rd = v;
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, input logic probe,
                        output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int k;
    model_access(we, adr, wd, f3, exp_rd, exp_err);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 3);
    rd  = rsp_rdata;
    err = rsp_err;
    check("rdata", rsp_rdata, exp_rd);
    check("err", {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      if (probe) begin
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h0; req_funct3 = 3'd2; req_wdata = 32'hBAD0BAD0;
      end
      @(posedge clk); #1;
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_req_l0(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [2:0] f3, output logic [31:0] rd);
    int k;
    z_req_valid = 1'b1; z_req_we = we; z_req_adr = adr; z_req_wdata = wd; z_req_funct3 = f3;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    k = 0;
    while (!z_rsp_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("l0_latency", k, 1);
    check("l0_err", {31'd0, z_rsp_err}, 32'd0);
    rd = z_rsp_rdata;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [2:0]  f;

    #1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_l0_valid", {31'd0, z_rsp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i*4), $urandom, 3'd2, 0, 1'b0, rd, er);

    // Directed cases.
    do_req(1'b1, 32'h10, 32'h12345678, 3'd2, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t1_lw", rd, 32'h12345678);
    do_req(1'b1, 32'h11, 32'h000000AB, 3'd0, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h11, 32'h0, 3'd4, 0, 1'b0, rd, er);
    check("t2_lbu", rd, 32'h000000AB);
    do_req(1'b0, 32'h11, 32'h0, 3'd0, 0, 1'b0, rd, er);
    check("t2_lb", rd, 32'hFFFFFFAB);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t2_lw", rd, 32'h1234AB78);
    do_req(1'b0, 32'h13, 32'h0, 3'd1, 0, 1'b0, rd, er);
    check("t3_lh_mis_err", {31'd0, er}, 32'd1);
    check("t3_lh_mis_rdata", rd, 32'd0);
    do_req(1'b1, 32'h12, 32'h00008642, 3'd1, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h12, 32'h0, 3'd5, 0, 1'b0, rd, er);
    check("t3_lhu", rd, 32'h00008642);
    do_req(1'b1, 32'h12, 32'hFFFFFFFF, 3'd2, 0, 1'b0, rd, er);
    check("t3_sw_mis_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t3_word_kept", rd, 32'h8642AB78);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 4, 1'b1, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t4_no_stray_write", rd, 32'h8642AB78);
    do_req(1'b0, 32'h100, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t6_oor_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 3'd3, 0, 1'b0, rd, er);
    check("t6_f3_011_err", {31'd0, er}, 32'd1);

    // Reset mid-WAIT drops the store.
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 0, 1'b0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h20; req_wdata = 32'hDEADBEEF; req_funct3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t5_prior", rd, 32'hCAFEF00D);

    // Zero-latency build.
    do_req_l0(1'b1, 32'h8, 32'hA5A55A5A, 3'd2, rd);
    do_req_l0(1'b0, 32'h8, 32'h0, 3'd2, rd);
    check("l0_lw", rd, 32'hA5A55A5A);

    // Random traffic, including out-of-range and illegal encodings.
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 32'h10F));
      f = 3'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom, f, $urandom_range(0, 2), 1'b0, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
